// File: rtl/cmos_pkg.sv
// Shared types and constants for the Gluk CMOS port front end.
package cmos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } cmos_state_t;

    localparam int          CMOS_SIZE = 240;
    localparam logic [15:0] PORT_ADDR = 16'hDFF7;
    localparam logic [15:0] PORT_DATA = 16'hBFF7;

endpackage

// File: rtl/cmos_port_queue.sv
// Pending-operation slots for the CMOS port: a one-entry write slot, a merged
// read flag, the sticky overrun bit and write-first priority selection.
module cmos_port_queue #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic       zclk,
    input  logic       rst_n,
    input  logic       gluk_en,
    input  logic       wr_addr_stb,
    input  logic       wr_data_stb,
    input  logic [7:0] din,
    input  logic [7:0] addr_reg,
    input  logic       take,
    output logic       sel_valid,
    output logic       sel_rnw,
    output logic [7:0] sel_addr,
    output logic [7:0] sel_data,
    output logic       overrun
);

    logic       pend_wr_reg;
    logic [7:0] pend_wr_addr_reg;
    logic [7:0] pend_wr_data_reg;
    logic       pend_rd_reg;
    logic       overrun_reg;

    always_ff @(posedge zclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_wr_reg      <= 1'b0;
            pend_wr_addr_reg <= 8'h00;
            pend_wr_data_reg <= 8'h00;
            pend_rd_reg      <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            if (take && pend_wr_reg)
                pend_wr_reg <= 1'b0;
            // A full slot drops the new write even if it is being launched now.
            if (gluk_en && wr_data_stb) begin
                if (pend_wr_reg) begin
                    overrun_reg <= 1'b1;
                end else begin
                    pend_wr_reg      <= 1'b1;
                    pend_wr_addr_reg <= addr_reg;
                    pend_wr_data_reg <= din;
                end
            end
            // A new address write re-arms the read even while the old one launches.
            if (!gluk_en)
                pend_rd_reg <= 1'b0;
            else if (PREFETCH && wr_addr_stb)
                pend_rd_reg <= 1'b1;
            else if (take && !pend_wr_reg)
                pend_rd_reg <= 1'b0;
        end
    end

    assign sel_valid = pend_wr_reg | pend_rd_reg;
    assign sel_rnw   = ~pend_wr_reg;
    assign sel_addr  = pend_wr_reg ? pend_wr_addr_reg : addr_reg;
    assign sel_data  = pend_wr_data_reg;
    assign overrun   = overrun_reg;

endmodule

// File: rtl/cmos_port.sv
// Z80-side CMOS port: address register, three-phase request FSM toward the
// CMOS store, and the registered read-back byte.
module cmos_port
    import cmos_pkg::*;
#(
    parameter bit         PREFETCH = 1'b1,
    parameter logic [7:0] RST_DOUT = 8'hFF
) (
    input  logic       zclk,
    input  logic       rst_n,
    input  logic       gluk_en,
    input  logic       wr_addr_stb,
    input  logic       wr_data_stb,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       overrun,
    output logic       cmos_req,
    output logic [7:0] cmos_addr,
    output logic       cmos_rnw,
    output logic [7:0] cmos_write,
    input  logic [7:0] cmos_read
);

    cmos_state_t state_reg, state_next;
    logic [7:0]  addr_reg;
    logic [7:0]  dout_reg;
    logic        cmos_req_reg;
    logic [7:0]  cmos_addr_reg;
    logic        cmos_rnw_reg;
    logic [7:0]  cmos_write_reg;
    logic        take;
    logic        sel_valid;
    logic        sel_rnw;
    logic [7:0]  sel_addr;
    logic [7:0]  sel_data;

    cmos_port_queue #(
        .PREFETCH (PREFETCH)
    ) u_queue (
        .zclk        (zclk),
        .rst_n       (rst_n),
        .gluk_en     (gluk_en),
        .wr_addr_stb (wr_addr_stb),
        .wr_data_stb (wr_data_stb),
        .din         (din),
        .addr_reg    (addr_reg),
        .take        (take),
        .sel_valid   (sel_valid),
        .sel_rnw     (sel_rnw),
        .sel_addr    (sel_addr),
        .sel_data    (sel_data),
        .overrun     (overrun)
    );

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    take       = 1'b1;
                    state_next = REQ;
                end
            end
            REQ:     state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge zclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= 8'h00;
            dout_reg       <= RST_DOUT;
            cmos_req_reg   <= 1'b0;
            cmos_addr_reg  <= 8'h00;
            cmos_rnw_reg   <= 1'b1;
            cmos_write_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            cmos_req_reg <= take;
            if (gluk_en && wr_addr_stb)
                addr_reg <= din;
            // cmos_* only change at launch, so they stay stable through REQ and HOLD.
            if (take) begin
                cmos_addr_reg <= sel_addr;
                cmos_rnw_reg  <= sel_rnw;
                if (!sel_rnw)
                    cmos_write_reg <= sel_data;
            end
            if (!gluk_en)
                dout_reg <= RST_DOUT;
            else if (state_reg == HOLD) begin
                if (cmos_rnw_reg)
                    dout_reg <= cmos_read;
                else if (cmos_addr_reg == addr_reg)
                    dout_reg <= cmos_write_reg;
            end
        end
    end

    assign dout       = dout_reg;
    assign busy       = (state_reg != IDLE) | sel_valid;
    assign cmos_req   = cmos_req_reg;
    assign cmos_addr  = cmos_addr_reg;
    assign cmos_rnw   = cmos_rnw_reg;
    assign cmos_write = cmos_write_reg;

endmodule

// File: tb/tb_cmos_port.sv
// Directed bench for cmos_port with a behavioural CMOS store model attached.
module tb_cmos_port;

    logic       zclk = 1'b0;
    logic       rst_n;
    logic       gluk_en;
    logic       wr_addr_stb;
    logic       wr_data_stb;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       overrun;
    logic       cmos_req;
    logic [7:0] cmos_addr;
    logic       cmos_rnw;
    logic [7:0] cmos_write;
    logic [7:0] cmos_read;

    int checks   = 0;
    int failures = 0;
    int reqs;

    always #5 zclk = ~zclk;

    cmos_port #(
        .PREFETCH (1'b1),
        .RST_DOUT (8'hFF)
    ) dut (
        .zclk        (zclk),
        .rst_n       (rst_n),
        .gluk_en     (gluk_en),
        .wr_addr_stb (wr_addr_stb),
        .wr_data_stb (wr_data_stb),
        .din         (din),
        .dout        (dout),
        .busy        (busy),
        .overrun     (overrun),
        .cmos_req    (cmos_req),
        .cmos_addr   (cmos_addr),
        .cmos_rnw    (cmos_rnw),
        .cmos_write  (cmos_write),
        .cmos_read   (cmos_read)
    );

    // Store model: 1-cycle registered read, write committed on the edge after req.
    logic [7:0] mem [0:255];
    logic       req_q;

    function automatic logic [7:0] init_val(input int i);
        if (i == 'h0B) return 8'h23;
        if (i == 'h20) return 8'h9C;
        return 8'(i) ^ 8'h55;
    endfunction

    always @(posedge zclk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            req_q     <= 1'b0;
            cmos_read <= 8'hFF;
        end else begin
            req_q     <= cmos_req;
            cmos_read <= (cmos_addr >= 8'd240) ? 8'hFF : mem[cmos_addr];
            if (req_q && !cmos_rnw) mem[cmos_addr] <= cmos_write;
        end
    end

    task automatic tick;
        @(posedge zclk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic count_reqs(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (cmos_req === 1'b1) cnt++;
        end
    endtask

    task automatic addr_wr(input logic [7:0] v);
        wr_addr_stb = 1'b1;
        din         = v;
        tick();
        wr_addr_stb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; gluk_en = 1'b1; wr_addr_stb = 1'b0; wr_data_stb = 1'b0; din = 8'h00;
        ticks(2);
        chk("rst_dout", dout, 8'hFF);
        chk("rst_req", {7'd0, cmos_req}, 8'h00);
        chk("rst_addr", cmos_addr, 8'h00);
        chk("rst_rnw", {7'd0, cmos_rnw}, 8'h01);
        chk("rst_write", cmos_write, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_overrun", {7'd0, overrun}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Prefetch read of 0x0B.
        addr_wr(8'h0B);
        chk("pf_busy", {7'd0, busy}, 8'h01);
        chk("pf_req_early", {7'd0, cmos_req}, 8'h00);
        tick();
        chk("pf_req", {7'd0, cmos_req}, 8'h01);
        chk("pf_addr", cmos_addr, 8'h0B);
        chk("pf_rnw", {7'd0, cmos_rnw}, 8'h01);
        tick();
        chk("pf_req_one", {7'd0, cmos_req}, 8'h00);
        tick();
        chk("pf_dout", dout, 8'h23);
        chk("pf_idle", {7'd0, busy}, 8'h00);

        // Address 0x0E, then data 0x5A to the same address.
        addr_wr(8'h0E);
        ticks(3);
        chk("a0e_dout", dout, 8'h5B);
        wr_data_stb = 1'b1; din = 8'h5A;
        tick();
        wr_data_stb = 1'b0;
        tick();
        chk("wr_req", {7'd0, cmos_req}, 8'h01);
        chk("wr_rnw", {7'd0, cmos_rnw}, 8'h00);
        chk("wr_addr", cmos_addr, 8'h0E);
        chk("wr_data", cmos_write, 8'h5A);
        ticks(2);
        chk("wr_dout", dout, 8'h5A);
        count_reqs(4, reqs);
        chk("wr_no_read", 8'(reqs), 8'h00);
        addr_wr(8'h0E);
        ticks(3);
        chk("wr_readback", dout, 8'h5A);

        // Data write during HOLD, second one dropped before launch.
        addr_wr(8'h30);
        ticks(2);
        wr_data_stb = 1'b1; din = 8'h11;
        tick();
        chk("ov_pf_dout", dout, 8'h65);
        din = 8'h22;
        tick();
        wr_data_stb = 1'b0;
        chk("ov_set", {7'd0, overrun}, 8'h01);
        chk("ov_req", {7'd0, cmos_req}, 8'h01);
        chk("ov_wdata", cmos_write, 8'h11);
        ticks(2);
        chk("ov_dout", dout, 8'h11);
        count_reqs(4, reqs);
        chk("ov_dropped", 8'(reqs), 8'h00);
        chk("ov_sticky", {7'd0, overrun}, 8'h01);

        // Same-cycle address and data strobes: write uses old addr_reg.
        addr_wr(8'h10);
        ticks(3);
        chk("both_pre", dout, 8'h45);
        wr_data_stb = 1'b1; wr_addr_stb = 1'b1; din = 8'h20;
        tick();
        wr_data_stb = 1'b0; wr_addr_stb = 1'b0;
        tick();
        chk("both_wr_rnw", {7'd0, cmos_rnw}, 8'h00);
        chk("both_wr_addr", cmos_addr, 8'h10);
        ticks(2);
        chk("both_dout_keep", dout, 8'h45);
        tick();
        chk("both_rd_rnw", {7'd0, cmos_rnw}, 8'h01);
        chk("both_rd_addr", cmos_addr, 8'h20);
        ticks(2);
        chk("both_rd_dout", dout, 8'h9C);
        addr_wr(8'h10);
        ticks(3);
        chk("both_readback", dout, 8'h20);

        // Out-of-range address, then gluk_en low.
        addr_wr(8'hF5);
        tick();
        chk("f5_addr", cmos_addr, 8'hF5);
        ticks(2);
        chk("f5_dout", dout, 8'hFF);
        addr_wr(8'h0B);
        ticks(3);
        chk("en_pre_dout", dout, 8'h23);
        gluk_en = 1'b0;
        tick();
        chk("dis_dout", dout, 8'hFF);
        wr_addr_stb = 1'b1; wr_data_stb = 1'b1; din = 8'h44;
        tick();
        wr_addr_stb = 1'b0; wr_data_stb = 1'b0;
        count_reqs(5, reqs);
        chk("dis_no_req", 8'(reqs), 8'h00);
        chk("dis_busy", {7'd0, busy}, 8'h00);
        gluk_en = 1'b1;
        tick();
        chk("reen_dout", dout, 8'hFF);

        // Reset asserted during REQ.
        addr_wr(8'h0B);
        tick();
        chk("rr_req", {7'd0, cmos_req}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rr_req0", {7'd0, cmos_req}, 8'h00);
        chk("rr_addr", cmos_addr, 8'h00);
        chk("rr_rnw", {7'd0, cmos_rnw}, 8'h01);
        chk("rr_busy", {7'd0, busy}, 8'h00);
        chk("rr_overrun", {7'd0, overrun}, 8'h00);
        chk("rr_dout", dout, 8'hFF);
        tick();
        rst_n = 1'b1;
        count_reqs(5, reqs);
        chk("rr_no_req", 8'(reqs), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
